// File: rtl/id_stage.sv
// Instruction-decode stage: 32x32 register file plus a valid/ready operand register feeding the ALU.
// Optional macro ID_WB_BYPASS_EN forwards a same-cycle write-back value into the captured operands.
module id_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    output logic        if_ready,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [31:0] ex_instr,
    output logic [31:0] ex_gr1,
    output logic [31:0] ex_gr2,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data
);

    logic [31:0] r_regs [1:31];
    logic [31:0] w_rf   [0:31];
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [31:0] w_op1;
    logic [31:0] w_op2;
    logic        w_accept;

    logic        r_ex_valid;
    logic [31:0] r_ex_instr;
    logic [31:0] r_ex_gr1;
    logic [31:0] r_ex_gr2;

    // Register 0 is a hardwired zero; only entries 1..31 hold state.
    assign w_rf[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_rf
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_regs[gi] <= '0;
                end else if (wb_en && (wb_addr == 5'(gi))) begin
                    r_regs[gi] <= wb_data;
                end
            end
            assign w_rf[gi] = r_regs[gi];
        end
    endgenerate

    assign w_rs = if_instr[25:21];
    assign w_rt = if_instr[20:16];

`ifdef ID_WB_BYPASS_EN
    assign w_op1 = (wb_en && (wb_addr == w_rs) && (w_rs != 5'd0)) ? wb_data : w_rf[w_rs];
    assign w_op2 = (wb_en && (wb_addr == w_rt) && (w_rt != 5'd0)) ? wb_data : w_rf[w_rt];
`else
    assign w_op1 = w_rf[w_rs];
    assign w_op2 = w_rf[w_rt];
`endif

    assign if_ready = !flush && (!r_ex_valid || ex_ready);
    assign w_accept = if_valid && if_ready;

    // Priority: flush, then new acceptance, then bubble on consumption; otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid <= 1'b0;
            r_ex_instr <= NOP_INSTR;
            r_ex_gr1   <= '0;
            r_ex_gr2   <= '0;
        end else if (flush) begin
            r_ex_valid <= 1'b0;
            r_ex_instr <= NOP_INSTR;
            r_ex_gr1   <= '0;
            r_ex_gr2   <= '0;
        end else if (w_accept) begin
            r_ex_valid <= 1'b1;
            r_ex_instr <= if_instr;
            r_ex_gr1   <= w_op1;
            r_ex_gr2   <= w_op2;
        end else if (ex_ready) begin
            r_ex_valid <= 1'b0;
        end
    end

    assign ex_valid = r_ex_valid;
    assign ex_instr = r_ex_instr;
    assign ex_gr1   = r_ex_gr1;
    assign ex_gr2   = r_ex_gr2;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: accepted instructions push expected operands, a forked
// monitor pops and compares whenever the ALU consumes an operation.
module tb_id_stage;

    localparam logic [31:0] TB_NOP = 32'h00000020;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_instr;
    logic        if_ready;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_instr;
    logic [31:0] ex_gr1;
    logic [31:0] ex_gr2;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] g1;
        logic [31:0] g2;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    id_stage #(.NOP_INSTR(TB_NOP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_valid (if_valid),
        .if_instr (if_instr),
        .if_ready (if_ready),
        .ex_valid (ex_valid),
        .ex_ready (ex_ready),
        .ex_instr (ex_instr),
        .ex_gr1   (ex_gr1),
        .ex_gr2   (ex_gr2),
        .flush    (flush),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && ex_valid && ex_ready && !flush) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL sb_empty: got op 0x%08h expected no operation", ex_instr);
                end else begin
                    e = sb.pop_front();
                    chk("ex_instr", ex_instr, e.instr);
                    chk("ex_gr1", ex_gr1, e.g1);
                    chk("ex_gr2", ex_gr2, e.g2);
                    $display("consumed instr=0x%08h gr1=0x%08h gr2=0x%08h", ex_instr, ex_gr1, ex_gr2);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        tick();
        wb_en = 1'b0;
    endtask

    // Present an instruction until accepted; expected operands enter the scoreboard at acceptance.
    task automatic issue(input logic [31:0] instr, input logic [31:0] e1, input logic [31:0] e2);
        bit done = 0;
        if_valid = 1'b1;
        if_instr = instr;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (if_ready) begin
                sb.push_back({instr, e1, e2});
                done = 1;
                tick();
            end
        end
        if_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_fails++;
            $display("FAIL issue_timeout: got if_ready=0 for 20 cycles expected acceptance of 0x%08h", instr);
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Reset with fetch and write-back active: both must be ignored.
        rst_n = 1'b0; if_valid = 1'b1; if_instr = 32'h00A52020; ex_ready = 1'b0;
        flush = 1'b0; wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_ex_instr", ex_instr, TB_NOP);
        chk("rst_ex_gr1", ex_gr1, 32'd0);
        chk("rst_ex_gr2", ex_gr2, 32'd0);
        chk("rst_if_ready", {31'd0, if_ready}, 32'd1);
        if_valid = 1'b0; wb_en = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("post_rst_ex_valid", {31'd0, ex_valid}, 32'd0);

        // reg5 was targeted only during reset, so it still reads 0.
        ex_ready = 1'b1;
        issue(32'h00A52020, 32'd0, 32'd0);

        // 0x014B4820 = add $9,$10,$11: rs=10, rt=11. reg9 is a distractor.
        wb(5'd9,  32'h11111111);
        wb(5'd10, 32'h89999999);
        wb(5'd11, 32'h5DDDDDDD);
        tick();
        ex_ready = 1'b0;
        issue(32'h014B4820, 32'h89999999, 32'h5DDDDDDD);

        // Stall 3 cycles; a write to reg10 mid-stall must not change the held operand.
        if_valid = 1'b1; if_instr = 32'h016A4822;
        wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'hA5A5A5A5;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_if_ready", {31'd0, if_ready}, 32'd0);
            chk("stall_ex_valid", {31'd0, ex_valid}, 32'd1);
            chk("stall_ex_instr", ex_instr, 32'h014B4820);
            chk("stall_ex_gr1", ex_gr1, 32'h89999999);
            chk("stall_ex_gr2", ex_gr2, 32'h5DDDDDDD);
            tick();
            wb_en = 1'b0;
        end
        // 0x016A4822 = sub $9,$11,$10: rs=11, rt=10.
        ex_ready = 1'b1;
        issue(32'h016A4822, 32'h5DDDDDDD, 32'hA5A5A5A5);
        chk("post_stall_ex_instr", ex_instr, 32'h016A4822);

        // 0x02328021 = addu $16,$17,$18 with a same-edge write to reg17.
        wb(5'd17, 32'h0BADF00D);
        wb(5'd18, 32'h00C0FFEE);
        wb_en = 1'b1; wb_addr = 5'd17; wb_data = 32'h12345678;
`ifdef ID_WB_BYPASS_EN
        issue(32'h02328021, 32'h12345678, 32'h00C0FFEE);
`else
        issue(32'h02328021, 32'h0BADF00D, 32'h00C0FFEE);
`endif
        wb_en = 1'b0;
        issue(32'h02328021, 32'h12345678, 32'h00C0FFEE);

        // Writes to register 0 are dropped, including one on the accepting edge.
        wb(5'd0, 32'hFFFFFFFF);
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
        issue(32'h00001820, 32'd0, 32'd0);
        wb_en = 1'b0;

        // Flush with a held op, an incoming op and ex_ready all asserted.
        tick();
        ex_ready = 1'b0;
        issue(32'h014B4820, 32'hA5A5A5A5, 32'h5DDDDDDD);
        if_valid = 1'b1; if_instr = 32'h016A4822; flush = 1'b1; ex_ready = 1'b1;
        @(negedge clk);
        chk("flush_if_ready", {31'd0, if_ready}, 32'd0);
        chk("flush_pre_ex_valid", {31'd0, ex_valid}, 32'd1);
        if (sb.size() > 0) void'(sb.pop_front());
        tick();
        flush = 1'b0; if_valid = 1'b0;
        chk("flush_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush_ex_instr", ex_instr, TB_NOP);
        chk("flush_ex_gr1", ex_gr1, 32'd0);
        chk("flush_ex_gr2", ex_gr2, 32'd0);

        // Reset asserted between edges while an op is stalled.
        ex_ready = 1'b0;
        issue(32'h02328021, 32'h12345678, 32'h00C0FFEE);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("midrst_ex_instr", ex_instr, TB_NOP);
        chk("midrst_ex_gr1", ex_gr1, 32'd0);
        chk("midrst_ex_gr2", ex_gr2, 32'd0);
        sb.delete();
        tick();
        rst_n = 1'b1;
        ex_ready = 1'b1;
        issue(32'h02328021, 32'd0, 32'd0);

        repeat (3) tick();
        chk("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
